// File: rtl/key_pkg.sv
// Shared constants for the key front end: clock rate, default timing, channel indices.
package key_pkg;
  localparam int unsigned KEY_CLK_HZ         = 25000000;
  localparam int unsigned KEY_DEBOUNCE_DEF   = KEY_CLK_HZ / 50;  // 20 ms
  localparam int unsigned KEY_REP_DELAY_DEF  = KEY_CLK_HZ / 2;   // 0.5 s
  localparam int unsigned KEY_REP_PERIOD_DEF = KEY_CLK_HZ / 10;  // 0.1 s

  localparam int unsigned KEY_IDX_UP    = 0;
  localparam int unsigned KEY_IDX_DOWN  = 1;
  localparam int unsigned KEY_IDX_LEFT  = 2;
  localparam int unsigned KEY_IDX_RIGHT = 3;

  function automatic int unsigned key_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, restart-on-bounce debouncer, press/release pulses.
// Auto-repeat of press pulses on held keys is added when KEY_REPEAT_EN is defined.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned REPEAT_DELAY    = KEY_REP_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = KEY_REP_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic level_nxt,
  output logic press,
  output logic rel
);
  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s0_q, s0_d, s1_q, s1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d, rel_q, rel_d;
  logic          sample, acc_press, rep_pulse;

  assign sample = s1_q ^ ACTIVE_LOW;

  always_comb begin
    s0_d      = key_in;
    s1_d      = s0_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    acc_press = 1'b0;
    rel_d     = 1'b0;
    // Any sample agreeing with the stable level throws away the partial count.
    if (sample == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d  = sample;
      cnt_d     = '0;
      acc_press = sample;
      rel_d     = ~sample;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned   HW       = $clog2(key_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [HW-1:0] HOLD_DLY = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_PER = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rep_q, rep_d;

  // rep_q selects the shorter threshold once the first repeat has fired.
  always_comb begin
    hold_d    = hold_q;
    rep_d     = rep_q;
    rep_pulse = 1'b0;
    if (!stable_q || !stable_d) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (hold_q == (rep_q ? HOLD_PER : HOLD_DLY)) begin
      hold_d    = '0;
      rep_d     = 1'b1;
      rep_pulse = 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign press_d = acc_press | rep_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q     <= ACTIVE_LOW;
      s1_q     <= ACTIVE_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level     = stable_q;
  assign level_nxt = stable_d;
  assign press     = press_q;
  assign rel       = rel_q;
endmodule

// File: rtl/key_debounce_array.sv
// N-channel debounced key front end; one pulse per accepted press/release.
// Define KEY_REPEAT_EN to enable auto-repeat press pulses while a key is held.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned REPEAT_DELAY    = KEY_REP_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = KEY_REP_PERIOD_DEF
) (
  input  logic                KEY_clk,
  input  logic                KEY_rst,
  input  logic [NUM_KEYS-1:0] KEY_in,
  output logic [NUM_KEYS-1:0] KEY_level,
  output logic [NUM_KEYS-1:0] KEY_press,
  output logic [NUM_KEYS-1:0] KEY_release,
  output logic                KEY_any
);
  logic [NUM_KEYS-1:0] level_nxt;
  logic                any_q, any_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk      (KEY_clk),
      .rst      (KEY_rst),
      .key_in   (KEY_in[i]),
      .level    (KEY_level[i]),
      .level_nxt(level_nxt[i]),
      .press    (KEY_press[i]),
      .rel      (KEY_release[i])
    );
  end

  // Built from next-state levels so KEY_any rises on the same edge as KEY_level.
  always_comb begin
    any_d = |level_nxt;
  end

  always_ff @(posedge KEY_clk or posedge KEY_rst) begin
    if (KEY_rst) any_q <= 1'b0;
    else         any_q <= any_d;
  end

  assign KEY_any = any_q;
endmodule

// File: tb/tb_key_debounce_array.sv
// Directed + random bench for key_debounce_array with a run-length based reference model.
module tb_key_debounce_array;
  localparam int NK = 4, DEB = 4, RD = 10, RP = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic [NK-1:0] kin = '0;
  logic [NK-1:0] lvl, prs, rel;
  logic          any;
  int            checks = 0, errors = 0;

  always #20 clk = ~clk;

  key_debounce_array #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .KEY_clk(clk), .KEY_rst(rst), .KEY_in(kin),
    .KEY_level(lvl), .KEY_press(prs), .KEY_release(rel), .KEY_any(any)
  );

  // Reference model: a key flips once its synchronised sample has held a new value
  // for DEB consecutive samples; repeats fire at RD, RD+RP, ... cycles of holding.
  logic [NK-1:0] m_s0, m_s1, m_st, m_prs, m_rel, m_last;
  logic          m_any;
  int            m_run [NK];
`ifdef KEY_REPEAT_EN
  int            m_held[NK];
`endif

  task automatic model_reset();
    m_s0 = '0; m_s1 = '0; m_st = '0; m_prs = '0; m_rel = '0; m_last = '0; m_any = 1'b0;
    for (int i = 0; i < NK; i++) begin
      m_run[i] = 0;
`ifdef KEY_REPEAT_EN
      m_held[i] = 0;
`endif
    end
  endtask

  task automatic model_step();
    logic smp;
    if (rst) begin
      model_reset();
      return;
    end
    m_prs = '0;
    m_rel = '0;
    for (int i = 0; i < NK; i++) begin
      smp = m_s1[i];
      if (smp == m_last[i]) m_run[i]++;
      else                  m_run[i] = 1;
      m_last[i] = smp;
      if (smp != m_st[i] && m_run[i] >= DEB) begin
        m_st[i]  = smp;
        m_prs[i] = smp;
        m_rel[i] = !smp;
`ifdef KEY_REPEAT_EN
        m_held[i] = 0;
`endif
      end
`ifdef KEY_REPEAT_EN
      else if (m_st[i]) begin
        m_held[i]++;
        if (m_held[i] >= RD && (m_held[i] - RD) % RP == 0) m_prs[i] = 1'b1;
      end
`endif
    end
    m_s1  = m_s0;
    m_s0  = kin;
    m_any = |m_st;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_level",   lvl, m_st);
    chk("model_press",   prs, m_prs);
    chk("model_release", rel, m_rel);
    chk("model_any",     any, m_any);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int first, np, nr, posts;
    logic [NK-1:0] rel_seen, prs_seen, any_seen, lvl_seen;
    int q[$];
    int exp_q[$];

    model_reset();
    #3;
    chk("reset_level", lvl, 0); chk("reset_press", prs, 0);
    chk("reset_release", rel, 0); chk("reset_any", any, 0);
    ticks(3);
    rst = 1'b0;
    ticks(3);

    // Clean press on channel 0: pulse after edge 5
    kin[0] = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("clean_early_press", prs[0], 0);
    end
    tick();
    chk("clean_press", prs[0], 1); chk("clean_level", lvl[0], 1); chk("clean_any", any, 1);
    tick();
    chk("clean_press_width", prs[0], 0); chk("clean_level_hold", lvl[0], 1);
    kin[0] = 1'b0;
    nr = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (rel[0]) nr++; end
    chk("clean_release_count", nr, 1); chk("clean_release_level", lvl[0], 0);

    // Bounce on channel 1, then settle high
    np = 0;
    for (int k = 0; k < 8; k++) begin
      kin[1] = ((k / 2) % 2 == 0);
      tick();
      if (prs[1]) np++;
    end
    chk("bounce_no_press", np, 0);
    kin[1] = 1'b1;
    first = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (prs[1]) begin np++; if (first < 0) first = t; end
    end
    chk("bounce_press_count", np, 1); chk("bounce_press_time", first, 5);
    kin[1] = 1'b0;
    ticks(10);

    // Short glitch on channel 2
    any_seen = '0; lvl_seen = '0; prs_seen = '0;
    kin[2] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) kin[2] = 1'b0;
      tick();
      any_seen[0] |= any; lvl_seen |= lvl; prs_seen |= prs;
    end
    chk("glitch_level", lvl_seen[2], 0); chk("glitch_press", prs_seen[2], 0);
    chk("glitch_any", any_seen[0], 0);

    // Simultaneous press of all four, then release channel 3 alone
    kin = 4'hF;
    tick();
    for (int k = 1; k <= 4; k++) begin tick(); chk("simul_early", prs, 0); end
    tick();
    chk("simul_press", prs, 4'hF); chk("simul_any", any, 1);
    tick();
    chk("simul_press_width", prs, 0);
    kin[3] = 1'b0;
    rel_seen = '0; prs_seen = '0;
    for (int k = 0; k < 8; k++) begin tick(); rel_seen |= rel; prs_seen |= prs; end
    chk("single_release", rel_seen, 4'b1000); chk("single_release_nopress", prs_seen[3], 0);
    kin = '0;
    ticks(10);

    // Reset mid-count: channels 1,2 held, channel 0 at count 2
    kin = 4'b0110;
    ticks(8);
    kin[0] = 1'b1;
    ticks(4);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_level", lvl, 0); chk("midrst_press", prs, 0);
    chk("midrst_release", rel, 0); chk("midrst_any", any, 0);
    ticks(2);
    rst = 1'b0;
    first = -1;
    for (int t = 0; t < 20 && first < 0; t++) begin
      tick();
      if (prs[0]) begin first = t; chk("midrst_press_all", prs, 4'b0111); end
    end
    chk("midrst_press_time", first, 5);
    kin = '0;
    ticks(10);

    // Long hold on channel 0: repeats only when enabled
    kin[0] = 1'b1;
    for (int t = 0; t <= 35; t++) begin tick(); if (prs[0]) q.push_back(t); end
`ifdef KEY_REPEAT_EN
    exp_q = '{5, 15, 18, 21, 24, 27, 30, 33};
`else
    exp_q = '{5};
`endif
    chk("hold_press_count", q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < q.size(); k++) chk("hold_press_time", q[k], exp_q[k]);
    kin[0] = 1'b0;
    nr = 0; posts = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (rel[0]) begin nr++; chk("release_no_coincident_press", prs[0], 0); end
      else if (nr > 0 && prs[0]) posts++;
    end
    chk("hold_release_count", nr, 1); chk("hold_no_press_after_release", posts, 0);
    ticks(4);

    // Random stimulus against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) kin[i] = ~kin[i];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
- Parametrised N-channel touch/push-key front end for the game core at 25 MHz.
- Per channel:
  - 2-flop synchroniser
  - counter-based debouncer
  - stable level output
  - one-cycle press and release pulses
- Replaces raw edge detection, which passes contact bounce as multiple moves. Outputs feed CORE_Gm direction inputs unchanged: one pulse equals one move.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a new level must persist before acceptance (20 ms at 25 MHz). Legal range ≥ 2.
- ACTIVE_LOW, 0: 0 means raw high = pressed; 1 means raw low = pressed. Inversion is applied after the synchroniser.
- REPEAT_DELAY, 12500000: cycles held before the first auto-repeat (0.5 s). Used only with KEY_REPEAT_EN.
- REPEAT_PERIOD, 2500000: cycles between auto-repeat pulses (0.1 s). Used only with KEY_REPEAT_EN. Legal range ≥ 1.

Ports:
- KEY_clk, input, 1: clock, 25 MHz.
- KEY_rst, input, 1: reset, asynchronous, active-high.
- KEY_in, input, NUM_KEYS: raw asynchronous key inputs. Bit i is channel i.
- KEY_level, output, NUM_KEYS: debounced pressed state (1 = pressed).
- KEY_press, output, NUM_KEYS: one-cycle pulse per accepted press (and per repeat, if enabled).
- KEY_release, output, NUM_KEYS: one-cycle pulse per accepted release.
- KEY_any, output, 1: OR of KEY_level.

Behaviour:
- Reset (async assert, released synchronously by the system):
  - Synchroniser flops load the released raw level (0 if ACTIVE_LOW=0, else 1).
  - Counters load 0 and stable state loads 0.
  - KEY_level, KEY_press, KEY_release and KEY_any are all 0.
  - Reset asserted mid-count or mid-hold discards all progress. No pulse is issued on reset entry or exit.
- Synchroniser: s0 <= KEY_in, s1 <= s0. Sample = s1 XOR ACTIVE_LOW.
- Counter:
  - Width is clog2(DEBOUNCE_CYCLES).
  - When sample == stable, counter <= 0.
  - When sample != stable and counter < DEBOUNCE_CYCLES-1, counter increments.
  - When sample != stable and counter == DEBOUNCE_CYCLES-1:
    - stable <= sample, counter <= 0;
    - KEY_press <= sample (new state pressed), or KEY_release <= !sample (new state released).
- Pulses are registered outputs, high exactly one cycle, then cleared the next edge unless re-triggered.
- Latency: call the first edge at which s0 captures the new raw level edge 0. Then stable, KEY_level and the pulse are high after edge DEBOUNCE_CYCLES+1.
- Glitch rejection: a level held for fewer than DEBOUNCE_CYCLES synchronised samples yields no change and no pulse; the counter returns to 0.
- A bounce inside the window restarts the count from 0. There is no partial credit.
- Channels are fully independent. Simultaneous presses produce pulses in the same cycle; there is no priority or arbitration.
- KEY_press and KEY_release of one channel are never high together.
- KEY_any is registered: high after the edge at which any stable bit becomes 1.
- The counter never wraps; it saturates by construction at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each channel adds a hold counter (width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)), cleared on accepted press and on release.
  - While stable = 1, the counter counts. After REPEAT_DELAY cycles KEY_press pulses again and the counter reloads, so that subsequent pulses occur every REPEAT_PERIOD cycles.
  - Release stops repeats the same edge that stable clears; no repeat pulse coincides with KEY_release.
- Undefined: hold counters are absent and exactly one KEY_press pulse is issued per accepted press, regardless of hold time.

Decomposition:
- Package key_pkg:
  - KEY_CLK_HZ = 25000000;
  - default DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD derived from KEY_CLK_HZ;
  - channel index constants KEY_IDX_UP=0, KEY_IDX_DOWN=1, KEY_IDX_LEFT=2, KEY_IDX_RIGHT=3.
- Sub-module key_debounce_chan: a single channel (sync, counter, stable, pulses, optional repeat). Instantiated NUM_KEYS times in a generate loop. The top adds only the KEY_any register.

Test Plan (NUM_KEYS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press and release:
  - KEY_in[0] 0→1 before edge 0, held → KEY_level[0]=1 and a KEY_press[0] pulse after edge 5, one cycle wide.
  - Later release held 4+ samples → KEY_release[0] one pulse and KEY_level[0]=0.
- Bounce: KEY_in[1] toggled 1,0,1,0 with 2-cycle phases, then held 1 → no pulse during the bounce; exactly one KEY_press[1], 5 edges after the final rise.
- Short glitch: KEY_in[2] high for 3 cycles only → KEY_level[2], KEY_press[2] and KEY_any all remain 0.
- Simultaneous: KEY_in=4'b1111 in one cycle → KEY_press=4'b1111 in the same single cycle and KEY_any=1. Then KEY_in[3] released alone → only KEY_release[3].
- Reset mid-count: assert KEY_rst asynchronously at count 2 of a press → all outputs 0 immediately. After deassert with KEY_in still high, a fresh full debounce (5 edges) precedes KEY_press.
- KEY_REPEAT_EN defined, KEY_in[0] held 30 cycles after acceptance → KEY_press[0] at acceptance, +10, +13, +16… Release → KEY_release[0] only, with no further presses. Undefined build → exactly one press.
